// File: rtl/obi_mem_responder_if.sv
// ============================================================================
// Module   : obi_mem_responder_if
// Brief    : req/gnt/rvalid memory bus between the data cache and its RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface obi_mem_responder_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/obi_mem_responder.sv
// ============================================================================
// Module   : obi_mem_responder
// Brief    : RAM-backed bus responder with programmable grant delay and
//            response latency. Optional OBI_MEM_RESP_ERR_EN flags misaligned
//            or out-of-range accesses with an error response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module obi_mem_responder #(
  parameter int    DEPTH        = 1024,
  parameter int    GNT_DELAY    = 0,
  parameter int    RESP_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input wire                 clk,
  input wire                 rst_n,
  obi_mem_responder_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int GCW = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;
  localparam int RCW = (RESP_LATENCY > 2) ? $clog2(RESP_LATENCY - 1) : 1;
  localparam logic [GCW-1:0] GNT_LOAD  = GCW'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);
  localparam logic [RCW-1:0] RESP_LOAD = RCW'((RESP_LATENCY > 1) ? RESP_LATENCY - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GNT_WAIT  = 3'd1,
    S_GRANT     = 3'd2,
    S_RESP_WAIT = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [GCW-1:0] gcnt, gcnt_nxt;
  logic [RCW-1:0] rcnt, rcnt_nxt;
  logic           gnt;
  logic           grant;
  logic           bad_addr;
  logic           wr_en;
  logic [AW-1:0]  idx;
  logic [31:0]    resp_data;
  logic [31:0]    mem [DEPTH];

  assign idx = bus.addr_i[AW+1:2];

`ifdef OBI_MEM_RESP_ERR_EN
  logic resp_err;

  assign bad_addr = ((bus.addr_i >> (AW + 2)) != 32'd0) || (bus.addr_i[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err <= 1'b0;
    end else if (grant) begin
      resp_err <= bad_addr;
    end
  end

  assign bus.err_o = resp_err;
`else
  logic unused_addr;

  assign bad_addr    = 1'b0;
  assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};
  assign bus.err_o   = 1'b0;
`endif

  // RESP shares IDLE's request handling so a new grant can overlap rvalid.
  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    rcnt_nxt  = rcnt;
    gnt       = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        if (bus.req_i) begin
          if (GNT_DELAY == 0) begin
            gnt = 1'b1;
          end else begin
            gcnt_nxt  = GNT_LOAD;
            state_nxt = (GNT_DELAY == 1) ? S_GRANT : S_GNT_WAIT;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GNT_WAIT: begin
        if (!bus.req_i) begin
          state_nxt = S_IDLE;
        end else if (gcnt <= GCW'(1)) begin
          gcnt_nxt  = '0;
          state_nxt = S_GRANT;
        end else begin
          gcnt_nxt = gcnt - GCW'(1);
        end
      end
      S_GRANT: begin
        gnt = 1'b1;
      end
      S_RESP_WAIT: begin
        if (rcnt == '0) begin
          state_nxt = S_RESP;
        end else begin
          rcnt_nxt = rcnt - RCW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (bus.req_i && gnt) begin
      rcnt_nxt  = RESP_LOAD;
      state_nxt = (RESP_LATENCY == 1) ? S_RESP : S_RESP_WAIT;
    end
  end

  // Gated by rst_n so the grant drops the instant reset asserts.
  assign bus.gnt_o    = gnt && rst_n;
  assign grant        = bus.req_i && bus.gnt_o;
  assign wr_en        = grant && bus.we_i && !bad_addr;
  assign bus.rvalid_o = (state == S_RESP);
  assign bus.rdata_o  = resp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gcnt      <= '0;
      rcnt      <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      gcnt  <= gcnt_nxt;
      rcnt  <= rcnt_nxt;
      if (grant) begin
        resp_data <= bad_addr  ? 32'hDEAD_BEEF :
                     bus.we_i  ? 32'h0000_0000 : mem[idx];
      end
    end
  end

  // RAM has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) begin
          mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
// ============================================================================
// Module   : tb_obi_mem_responder
// Brief    : Scoreboard bench over three responder timings sharing one driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt_m, rvalid_m, err_m;
  logic [31:0] rdata_m;

  logic [32:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;
  bit          pending = 1'b0;
  int          wn;

  always #5 clk = ~clk;

  obi_mem_responder_if ia ();
  obi_mem_responder_if ib ();
  obi_mem_responder_if ic ();

  assign ia.req_i = req && (sel == 2'd0);
  assign ib.req_i = req && (sel == 2'd1);
  assign ic.req_i = req && (sel == 2'd2);
  assign ia.addr_i = addr;  assign ib.addr_i = addr;  assign ic.addr_i = addr;
  assign ia.we_i   = we;    assign ib.we_i   = we;    assign ic.we_i   = we;
  assign ia.be_i   = be;    assign ib.be_i   = be;    assign ic.be_i   = be;
  assign ia.wdata_i = wdata; assign ib.wdata_i = wdata; assign ic.wdata_i = wdata;

  assign gnt_m    = (sel == 2'd0) ? ia.gnt_o    : (sel == 2'd1) ? ib.gnt_o    : ic.gnt_o;
  assign rvalid_m = (sel == 2'd0) ? ia.rvalid_o : (sel == 2'd1) ? ib.rvalid_o : ic.rvalid_o;
  assign rdata_m  = (sel == 2'd0) ? ia.rdata_o  : (sel == 2'd1) ? ib.rdata_o  : ic.rdata_o;
  assign err_m    = (sel == 2'd0) ? ia.err_o    : (sel == 2'd1) ? ib.err_o    : ic.err_o;

  obi_mem_responder #(.DEPTH(1024), .GNT_DELAY(0), .RESP_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  obi_mem_responder #(.DEPTH(1024), .GNT_DELAY(0), .RESP_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));
  obi_mem_responder #(.DEPTH(1024), .GNT_DELAY(3), .RESP_LATENCY(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic));

  // Monitor: pops one expected response per rvalid and polices one-outstanding.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (req && gnt_m) begin
        total++;
        if (pending && !rvalid_m) begin
          bad++;
          $display("FAIL early_grant: got grant while response pending, want no grant");
        end
      end
      if (rvalid_m) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rvalid: got rdata=%h err=%b, want no response", rdata_m, err_m);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({err_m, rdata_m} !== e) begin
            bad++;
            $display("FAIL resp: got err=%b rdata=%h, want err=%b rdata=%h",
                     err_m, rdata_m, e[32], e[31:0]);
          end
        end
        pending = 1'b0;
      end
      if (req && gnt_m) pending = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the grant edge.
  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [31:0] er, input logic ee,
                     output int waits);
    exp_q.push_back({ee, er});
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!gnt_m && waits < 50);
    if (!gnt_m) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got no grant after %0d cycles, want grant", waits);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 2'd0; req = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("reset_outputs", {29'd0, gnt_m, rvalid_m, err_m, rdata_m}, 64'd0);
    end
    sel = 2'd0;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read on zero-delay, latency-1 responder
    txn(1'b1, 32'h100, 4'hF, 32'hCAFE_BABE, 32'h0, 1'b0, wn);
    check("gnt_same_cycle", 64'(wn), 64'd1);
    @(negedge clk);
    check("rvalid_next_cycle", {63'd0, rvalid_m}, 64'd1);
    @(posedge clk);
    #1;
    txn(1'b0, 32'h100, 4'h0, 32'h0, 32'hCAFE_BABE, 1'b0, wn);
    txn(1'b1, 32'h104, 4'hF, 32'h1122_3344, 32'h0, 1'b0, wn);
    txn(1'b1, 32'h104, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, wn);
    txn(1'b0, 32'h104, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0, wn);
    txn(1'b1, 32'h104, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, wn);
    txn(1'b0, 32'h104, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0, wn);
    txn(1'b1, 32'h108, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, wn);
    txn(1'b0, 32'h108, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, wn);
    drain();

    // Out-of-range and misaligned accesses
    txn(1'b1, 32'h0, 4'hF, 32'h5A5A_0001, 32'h0, 1'b0, wn);
`ifdef OBI_MEM_RESP_ERR_EN
    txn(1'b1, 32'h1000, 4'hF, 32'h7777_8888, 32'hDEAD_BEEF, 1'b1, wn);
    txn(1'b0, 32'h0, 4'h0, 32'h0, 32'h5A5A_0001, 1'b0, wn);
    txn(1'b0, 32'h102, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, wn);
`else
    txn(1'b1, 32'h1000, 4'hF, 32'h7777_8888, 32'h0, 1'b0, wn);
    txn(1'b0, 32'h0, 4'h0, 32'h0, 32'h7777_8888, 1'b0, wn);
    txn(1'b0, 32'h102, 4'h0, 32'h0, 32'hCAFE_BABE, 1'b0, wn);
`endif
    drain();

    // Refill burst on the latency-2 responder
    sel = 2'd1;
    for (int i = 0; i < 4; i++)
      txn(1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i * 32'h0101), 32'h0, 1'b0, wn);
    drain();
    for (int i = 0; i < 4; i++)
      txn(1'b0, 32'h200 + 32'(4 * i), 4'h0, 32'h0, 32'hA000_0000 + 32'(i * 32'h0101), 1'b0, wn);
    drain();

    // Reset while a read sits in RESP_WAIT
    txn(1'b1, 32'h300, 4'hF, 32'h1234_5678, 32'h0, 1'b0, wn);
    drain();
    req = 1'b1; we = 1'b0; addr = 32'h300;
    @(negedge clk);
    check("rst_pre_gnt", {63'd0, gnt_m}, 64'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", {63'd0, gnt_m}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid_m}, 64'd0);
    check("rst_rdata", {32'd0, rdata_m}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b0, 32'h300, 4'h0, 32'h0, 32'h1234_5678, 1'b0, wn);
    drain();

    // Grant delay 3, latency 4: cycle-exact strobes
    sel = 2'd2;
    exp_q.push_back({1'b0, 32'h0});
    req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'hF; wdata = 32'h0000_00C3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("gnt_cycle%0d", c), {63'd0, gnt_m}, {63'd0, (c == 3)});
      check($sformatf("rvalid_cycle%0d", c), {63'd0, rvalid_m}, {63'd0, (c == 7)});
      @(posedge clk);
      if (c == 3) begin
        #1;
        req = 1'b0;
      end
    end
    #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
